// File: rtl/bg_vram_arbiter.sv
// Single-port background VRAM arbiter: fixed display priority, starvation-guarded CPU
// access, and a tag pipeline that steers RAM read data back to whoever issued the read.
module bg_vram_arbiter #(
   parameter int unsigned RD_LAT = 1,
   parameter logic [3:0]  STARVE = 4'd15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        disp_req,
   input  logic [10:0] disp_addr,
   output logic [8:0]  disp_data,
   output logic        disp_valid,
   output logic        disp_miss,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [10:0] cpu_addr,
   input  logic [8:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [8:0]  cpu_rdata,
   output logic [10:0] ram_addr,
   output logic [8:0]  ram_din,
   output logic        ram_we,
   input  logic [8:0]  ram_dout
);

   typedef enum logic [1:0] {StIdle, StRdWait, StAck} cpu_state_e;
   typedef enum logic [1:0] {TagNone, TagDisp, TagCpu} tag_e;

   cpu_state_e  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   tag_e        tag_q [0:RD_LAT];
   tag_e        tag_d [0:RD_LAT];
   tag_e        tag_ret;

   logic [10:0] ram_addr_q, ram_addr_d;
   logic [8:0]  ram_din_q, ram_din_d;
   logic        ram_we_q, ram_we_d;
   logic [8:0]  disp_data_q;
   logic        disp_valid_q;
   logic        disp_miss_q;
   logic [8:0]  cpu_rdata_q;

   logic        cpu_idle;
   logic        starving;
   logic        disp_grant;
   logic        cpu_grant;

   assign tag_ret    = tag_q[RD_LAT];
   assign cpu_idle   = (state_q == StIdle);
   assign starving   = cpu_idle && cpu_req && (wait_cnt_q == STARVE);
   assign disp_grant = disp_req && !starving;
   assign cpu_grant  = !disp_grant && cpu_idle && cpu_req;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cpu_grant) state_d = cpu_we ? StAck : StRdWait;
         StRdWait: if (tag_ret == TagCpu) state_d = StAck;
         StAck:    state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Counts only cycles where the CPU was eligible but lost; saturates at the guard level.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!cpu_req || cpu_grant) begin
         wait_cnt_d = 4'd0;
      end else if (cpu_idle && (wait_cnt_q != STARVE)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end
   end

   always_comb begin
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = 1'b0;
      if (disp_grant) begin
         ram_addr_d = disp_addr;
      end else if (cpu_grant) begin
         ram_addr_d = cpu_addr;
         if (cpu_we) begin
            ram_din_d = cpu_wdata;
            ram_we_d  = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i <= RD_LAT; i++) tag_d[i] = TagNone;
      if (disp_grant) begin
         tag_d[0] = TagDisp;
      end else if (cpu_grant && !cpu_we) begin
         tag_d[0] = TagCpu;
      end
      for (int unsigned i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         wait_cnt_q   <= 4'd0;
         for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= TagNone;
         ram_addr_q   <= 11'd0;
         ram_din_q    <= 9'd0;
         ram_we_q     <= 1'b0;
         disp_data_q  <= 9'd0;
         disp_valid_q <= 1'b0;
         disp_miss_q  <= 1'b0;
         cpu_rdata_q  <= 9'd0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         tag_q        <= tag_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         ram_we_q     <= ram_we_d;
         disp_valid_q <= (tag_ret == TagDisp);
         disp_miss_q  <= disp_req && starving;
         if (tag_ret == TagDisp) disp_data_q <= ram_dout;
         if ((state_q == StRdWait) && (tag_ret == TagCpu)) cpu_rdata_q <= ram_dout;
      end
   end

   assign disp_data  = disp_data_q;
   assign disp_valid = disp_valid_q;
   assign disp_miss  = disp_miss_q;
   assign cpu_ack    = (state_q == StAck);
   assign cpu_rdata  = cpu_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_din    = ram_din_q;
   assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_bg_vram_arbiter.sv
// Bench for bg_vram_arbiter: directed scenario tasks plus a randomized run checked against
// a transaction-level model (shadow memory + expected-event timeline).
module tb_bg_vram_arbiter;

   localparam int unsigned RD_LAT = 1;
   localparam logic [3:0]  STARVE = 4'd15;
   localparam int          NR     = 600;
   localparam int          NE     = NR + 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        disp_req = 1'b0;
   logic [10:0] disp_addr = '0;
   logic [8:0]  disp_data;
   logic        disp_valid;
   logic        disp_miss;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [10:0] cpu_addr = '0;
   logic [8:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [8:0]  cpu_rdata;
   logic [10:0] ram_addr;
   logic [8:0]  ram_din;
   logic        ram_we;
   logic [8:0]  ram_dout;

   logic [41:0] all_out;
   assign all_out = {ram_addr, ram_din, ram_we, disp_data, disp_valid, disp_miss, cpu_ack,
                     cpu_rdata};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bg_vram_arbiter #(.RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .disp_miss  (disp_miss),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout)
   );

   // Behavioural single-port RAM, RD_LAT = 1, read returns old data on a write cycle.
   logic [8:0] mem [2048];
   logic       preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 9'(i) ^ 9'h1A5;
      end else begin
         ram_dout <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= ram_din;
      end
   end

   function automatic logic [8:0] pre(input int a);
      return 9'(a) ^ 9'h1A5;
   endfunction

   task automatic idle_inputs();
      disp_req  = 1'b0;
      disp_addr = '0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      preload = 1'b0;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      disp_req  = 1'b1;
      disp_addr = 11'd3;
      @(negedge clk);
      checks++;
      if (ram_addr !== 11'd3) begin
         errors++;
         $display("FAIL reset_pre_addr: got %0d want 3", ram_addr);
      end
      disp_req = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_midread_outputs: got %h want 0", all_out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (disp_valid !== 1'b0 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_dropped_read: valid=%b we=%b ack=%b want 0", disp_valid,
                     ram_we, cpu_ack);
         end
      end
   endtask

   task automatic test_disp_stream();
      localparam int L = 20;
      logic exp_v;
      for (int i = 0; i < L + 3; i++) begin
         disp_req  = (i < L);
         disp_addr = 11'(i);
         @(negedge clk);
         exp_v = (i >= 2) && (i - 2 < L);
         checks++;
         if (disp_valid !== exp_v) begin
            errors++;
            $display("FAIL stream_valid[%0d]: got %b want %b", i, disp_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (disp_data !== pre(i - 2)) begin
               errors++;
               $display("FAIL stream_data[%0d]: got %h want %h", i, disp_data, pre(i - 2));
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_cpu_write_read();
      int         lat;
      logic [8:0] rd;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 11'd700;
      cpu_wdata = 9'h0F3;
      @(negedge clk);
      checks++;
      if ({ram_we, cpu_ack, ram_addr, ram_din} !== {1'b1, 1'b1, 11'd700, 9'h0F3}) begin
         errors++;
         $display("FAIL wr_grant: we=%b ack=%b addr=%0d din=%h want 1 1 700 0f3", ram_we,
                  cpu_ack, ram_addr, ram_din);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
         errors++;
         $display("FAIL wr_one_cycle: we=%b ack=%b want 0 0", ram_we, cpu_ack);
      end
      cpu_req = 1'b1;
      cpu_we  = 1'b0;
      lat = -1;
      rd  = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cpu_ack === 1'b1 && lat < 0) begin
            lat     = i;
            rd      = cpu_rdata;
            cpu_req = 1'b0;
         end
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL rd_latency: got %0d want 2", lat);
      end
      checks++;
      if (rd !== 9'h0F3) begin
         errors++;
         $display("FAIL rd_data: got %h want 0f3", rd);
      end
      checks++;
      if (cpu_rdata !== 9'h0F3) begin
         errors++;
         $display("FAIL rd_data_hold: got %h want 0f3", cpu_rdata);
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      logic g, exp_v;
      for (int i = 0; i < 42; i++) begin
         disp_req  = 1'b1;
         disp_addr = 11'(i);
         cpu_req   = (i <= 15) || (i >= 20 && i <= 35);
         cpu_we    = 1'b1;
         cpu_addr  = (i < 20) ? 11'd100 : 11'd101;
         cpu_wdata = (i < 20) ? 9'h055 : 9'h0AA;
         @(negedge clk);
         g     = (i == 15) || (i == 35);
         exp_v = (i >= 2) && (i - 2 != 15) && (i - 2 != 35);
         checks++;
         if ({cpu_ack, ram_we, disp_miss} !== {g, g, g}) begin
            errors++;
            $display("FAIL starve_grant[%0d]: ack/we/miss=%b%b%b want %b%b%b", i, cpu_ack,
                     ram_we, disp_miss, g, g, g);
         end
         checks++;
         if (disp_valid !== exp_v) begin
            errors++;
            $display("FAIL starve_valid[%0d]: got %b want %b", i, disp_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (disp_data !== pre(i - 2)) begin
               errors++;
               $display("FAIL starve_data[%0d]: got %h want %h", i, disp_data, pre(i - 2));
            end
         end
      end
      idle_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_interleave();
      logic ev, ea;
      for (int i = 0; i < 7; i++) begin
         disp_req  = (i == 0) || (i == 2);
         disp_addr = (i == 0) ? 11'd5 : 11'd6;
         cpu_req   = (i <= 3);
         cpu_we    = 1'b0;
         cpu_addr  = 11'd9;
         @(negedge clk);
         ev = (i == 2) || (i == 4);
         ea = (i == 3);
         checks++;
         if (disp_valid !== ev || cpu_ack !== ea) begin
            errors++;
            $display("FAIL ilv_order[%0d]: valid=%b ack=%b want %b %b", i, disp_valid, cpu_ack,
                     ev, ea);
         end
         if (ev) begin
            checks++;
            if (disp_data !== pre(i == 2 ? 5 : 6)) begin
               errors++;
               $display("FAIL ilv_disp_data[%0d]: got %h want %h", i, disp_data,
                        pre(i == 2 ? 5 : 6));
            end
         end
         if (ea) begin
            checks++;
            if (cpu_rdata !== pre(9)) begin
               errors++;
               $display("FAIL ilv_cpu_data: got %h want %h", cpu_rdata, pre(9));
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic g;
      int   n_ack = 0;
      for (int i = 0; i < 7; i++) begin
         cpu_req   = (i <= 2);
         cpu_we    = 1'b1;
         cpu_addr  = (i == 0) ? 11'd200 : 11'd201;
         cpu_wdata = (i == 0) ? 9'h011 : 9'h022;
         @(negedge clk);
         g = (i == 0) || (i == 2);
         if (cpu_ack === 1'b1) n_ack++;
         checks++;
         if (cpu_ack !== g || ram_we !== g) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: ack=%b we=%b want %b", i, cpu_ack, ram_we, g);
         end
         if (g) begin
            checks++;
            if (ram_addr !== (i == 0 ? 11'd200 : 11'd201) ||
                ram_din !== (i == 0 ? 9'h011 : 9'h022)) begin
               errors++;
               $display("FAIL b2b_write[%0d]: addr=%0d din=%h", i, ram_addr, ram_din);
            end
         end
      end
      checks++;
      if (n_ack != 2) begin
         errors++;
         $display("FAIL b2b_ack_count: got %0d want 2", n_ack);
      end
      idle_inputs();
   endtask

   bit         ev_dv  [NE];
   logic [8:0] ev_dd  [NE];
   bit         ev_ack [NE];
   bit         ev_rdu [NE];
   logic [8:0] ev_rd  [NE];
   logic [8:0] shadow [2048];

   task automatic test_random();
      bit          c_act = 0, c_we = 0;
      logic [10:0] c_addr = '0;
      logic [8:0]  c_wdata = '0;
      int          c_ack_at = -1, free_at = 0, denied = 0;
      int unsigned pct;
      bit          elig, starving, dgrant, cgrant, live;
      logic        m_miss = 0, m_we = 0;
      logic [10:0] m_addr = '0;
      logic [8:0]  m_din = '0, m_rdata = '0;

      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 2048; a++) shadow[a] = mem[a];
      for (int k = 0; k < NE; k++) begin
         ev_dv[k] = 0; ev_ack[k] = 0; ev_rdu[k] = 0; ev_dd[k] = '0; ev_rd[k] = '0;
      end

      for (int e = 0; e < NR + 10; e++) begin
         live = (e < NR);
         case ((e / 100) % 4)
            0:       pct = 50;
            1:       pct = 100;
            2:       pct = 0;
            default: pct = 85;
         endcase
         disp_req  = live && ($urandom_range(0, 99) < pct);
         disp_addr = 11'($urandom_range(0, 63));
         if (!c_act && live && $urandom_range(0, 2) == 0) begin
            c_act   = 1;
            c_we    = 1'($urandom_range(0, 1));
            c_addr  = 11'($urandom_range(0, 63));
            c_wdata = 9'($urandom_range(0, 511));
         end
         cpu_req   = c_act;
         cpu_we    = c_we;
         cpu_addr  = c_addr;
         cpu_wdata = c_wdata;

         // Predict what the coming edge does.
         elig     = c_act && (e >= free_at);
         starving = elig && (denied == int'(STARVE));
         dgrant   = disp_req && !starving;
         cgrant   = elig && !dgrant;
         m_miss   = disp_req && starving;
         m_we     = cgrant && c_we;
         if (dgrant) begin
            m_addr       = disp_addr;
            ev_dv[e + 2] = 1;
            ev_dd[e + 2] = shadow[disp_addr];
         end
         if (cgrant) begin
            m_addr = c_addr;
            if (c_we) begin
               m_din          = c_wdata;
               shadow[c_addr] = c_wdata;
               c_ack_at       = e;
            end else begin
               c_ack_at          = e + 2;
               ev_rdu[c_ack_at]  = 1;
               ev_rd[c_ack_at]   = shadow[c_addr];
            end
            ev_ack[c_ack_at] = 1;
            free_at          = c_ack_at + 2;
         end
         if (!c_act || cgrant) denied = 0;
         else if (elig && denied < int'(STARVE)) denied++;

         @(negedge clk);
         checks++;
         if (disp_valid !== ev_dv[e]) begin
            errors++;
            $display("FAIL rand_disp_valid[%0d]: got %b want %b", e, disp_valid, ev_dv[e]);
         end
         if (ev_dv[e]) begin
            checks++;
            if (disp_data !== ev_dd[e]) begin
               errors++;
               $display("FAIL rand_disp_data[%0d]: got %h want %h", e, disp_data, ev_dd[e]);
            end
         end
         checks++;
         if (cpu_ack !== ev_ack[e]) begin
            errors++;
            $display("FAIL rand_cpu_ack[%0d]: got %b want %b", e, cpu_ack, ev_ack[e]);
         end
         if (ev_rdu[e]) m_rdata = ev_rd[e];
         checks++;
         if (cpu_rdata !== m_rdata) begin
            errors++;
            $display("FAIL rand_cpu_rdata[%0d]: got %h want %h", e, cpu_rdata, m_rdata);
         end
         checks++;
         if ({disp_miss, ram_we, ram_addr, ram_din} !== {m_miss, m_we, m_addr, m_din}) begin
            errors++;
            $display("FAIL rand_ram_port[%0d]: miss/we/addr/din=%b %b %0d %h want %b %b %0d %h",
                     e, disp_miss, ram_we, ram_addr, ram_din, m_miss, m_we, m_addr, m_din);
         end
         if (c_act && c_ack_at == e) c_act = 0;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_disp_stream();
      test_cpu_write_read();
      test_starvation();
      test_interleave();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bg_vram_arbiter.md
# bg_vram_arbiter

Arbiter and sequencer for the single-port background VRAM (2048 × 9-bit words, three packed 3-bit palette indices per word). It shares the RAM between the background fill pipeline, which needs a read every pixel triplet, and the CPU/GPU command port, which loads tile data. The display side has fixed priority. A starvation guard guarantees CPU progress. The block sits between the background filler, the command interface and the `BG_vram` instance, and owns every RAM port signal.

## Interface
- `RD_LAT`, 1: RAM read latency in clock edges, from `ram_addr` presented to `ram_dout` valid; legal values 1–3.
- `STARVE`, 4'd15: consecutive denied CPU cycles after which the CPU wins one grant over the display.
- `clk`  in  1  pixel/system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `disp_req`  in  1  display read request, single-cycle, no handshake.
- `disp_addr`  in  11  display read address.
- `disp_data`  out  9  display read data.
- `disp_valid`  out  1  `disp_data` valid pulse.
- `disp_miss`  out  1  pulse: a display request was dropped for a starvation grant.
- `cpu_req`  in  1  CPU request; held high with `cpu_we`, `cpu_addr` and `cpu_wdata` stable until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  11  CPU address.
- `cpu_wdata`  in  9  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  9  read data, valid when `cpu_ack` is high after a read.
- `ram_addr`  out  11  RAM address, registered.
- `ram_din`  out  9  RAM write data, registered.
- `ram_we`  out  1  RAM write enable, registered.
- `ram_dout`  in  9  RAM read data.

## Operation
- **Reset.** While `rst_n` is low, all outputs are 0, the state is IDLE, `wait_cnt` is 0 and the read-tag pipeline is cleared.
  - Reset mid-operation drops any in-flight read; no `disp_valid` or `cpu_ack` is produced for it.
- **Grant decision.** Evaluated each edge from the sampled inputs. Exactly one grant or none per edge.
  1. `disp_req` and not starving → display read. `ram_addr` = `disp_addr`, `ram_we` = 0.
  2. Otherwise, CPU grant when state is IDLE and `cpu_req` is high. `ram_addr` = `cpu_addr`; for a write also `ram_we` = 1 and `ram_din` = `cpu_wdata`.
  3. Otherwise, no-op. `ram_we` = 0; `ram_addr` and `ram_din` hold their last values.
- **Starving condition.** `wait_cnt == STARVE` and state IDLE and `cpu_req` high. The CPU is granted. If `disp_req` is high in the same cycle, `disp_miss` pulses after that edge and no `disp_valid` is ever produced for that request.
- **wait_cnt** (4-bit).
  - Increments on each edge where `cpu_req` is high, state is IDLE and the CPU is not granted.
  - Clears on a CPU grant or when `cpu_req` is low.
  - Saturates at `STARVE`.
- **CPU FSM.**
  - IDLE → ACK on a write grant.
  - IDLE → RD_WAIT on a read grant.
  - RD_WAIT → ACK when the CPU tag exits the read pipeline.
  - ACK → IDLE unconditionally. `cpu_ack` is high exactly while in ACK.
  - The CPU is never granted in RD_WAIT or ACK, so at most one CPU transaction is outstanding.
- **Read pipeline.** An (RD_LAT+1)-stage tag shift register with tags {none, disp, cpu} routes `ram_dout` back to the requester.
  - Display and CPU reads can be interleaved freely.
  - Return order equals issue order.
- **cpu_rdata.** Captured together with `cpu_ack` and held until the next CPU read returns. It is 0 after reset.
- **Write-then-read hazard.** The RAM returns old data for a same-cycle read/write to one address. This cannot occur here because only one access is made per cycle.

## Timing
- **Display read** sampled at edge k:
  - `ram_addr` updates after k.
  - `ram_dout` is valid after k+RD_LAT.
  - `disp_data`/`disp_valid` are registered after k+RD_LAT+1.
  - Total latency RD_LAT+1 edges (2 at the default). Throughput is 1 per cycle.
- **CPU write** granted at edge k: `ram_we` is high for the one cycle after k. `cpu_ack` is high in that same cycle.
- **CPU read** granted at edge k: `cpu_ack` and `cpu_rdata` appear after k+RD_LAT+1.
- **After `cpu_ack`:** the requester either drops `cpu_req` or presents the next transaction before the following edge. The earliest next CPU grant is the edge after ACK.
- **Worst-case CPU wait** under continuous display traffic: `STARVE`+1 edges to grant.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-read (`disp_req` at edge k, reset before k+2) → `disp_valid` stays 0, all outputs 0, `ram_we` = 0.
- **Display streaming:** `disp_req` high every cycle, addr 0,1,2…, RAM preloaded with addr^9'h1A5 → `disp_valid` continuous from 2 cycles after the first request, data matches addr^9'h1A5 in order.
- **CPU write then read, no display traffic:** write 9'h0F3 to 11'd700 → `ram_we` high one cycle, `cpu_ack` the same cycle. Then read 11'd700 → `cpu_ack` 2 edges after grant with `cpu_rdata` = 9'h0F3.
- **Starvation:** `disp_req` held high, `cpu_req` write raised at edge k → CPU granted at edge k+15, `disp_miss` pulses once, display resumes the next cycle, `wait_cnt` back to 0.
- **Interleaving:** display read at edge k (addr 5), CPU read granted at k+1 (addr 9), display read at k+2 (addr 6) → returns in order: `disp_valid` at k+2 (word 5), `cpu_ack` at k+3 (word 9), `disp_valid` at k+4 (word 6).
- **Back-to-back CPU:** two writes with `cpu_req` held high across the ack → the second grant occurs exactly one edge after the ACK cycle, and exactly two `cpu_ack` pulses are observed.
